// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, uart_cr field positions
// and the baud-rate table used by both uart_tx and uart_rx.
package uart_pkg;

  localparam int unsigned CR_RE      = 0;
  localparam int unsigned CR_TE      = 1;
  localparam int unsigned CR_PSEL    = 2;
  localparam int unsigned CR_PEN     = 3;
  localparam int unsigned CR_STOP2   = 5;
  localparam int unsigned CR_BAUD_LO = 8;
  localparam int unsigned CR_BAUD_HI = 11;

  localparam logic [31:0] BAUD_RESET = 32'd13020;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    RECV,
    PARITY,
    STOP_BIT1,
    STOP_BIT2,
    FINISH
  } uart_state_e;

  // Clocks per bit for each baud code; unused codes keep the previous value.
  function automatic logic [31:0] baud_max(input logic [3:0] code,
                                           input logic [31:0] prev);
    logic [31:0] res;
    case (code)
      4'd0:    res = 32'd13020;
      4'd1:    res = 32'd6510;
      4'd2:    res = 32'd3255;
      4'd3:    res = 32'd2170;
      4'd4:    res = 32'd1085;
      4'd5:    res = 32'd125;
      4'd6:    res = 32'd62;
      4'd7:    res = 32'd41;
      4'd8:    res = 32'd31;
      4'd9:    res = 32'd25;
      4'd10:   res = 32'd135;
      4'd11:   res = 32'd542;
      4'd12:   res = 32'd271;
      default: res = prev;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bundle between the serial line / control register and the
// register/FIFO layer. The receiver is the master: it drives the results.
interface uart_rx_if;
  logic        rx;
  logic [11:0] uart_cr;
  logic [7:0]  po_data;
  logic        po_flag;
  logic        parity_err;
  logic        frame_err;
  logic        rx_busy;

  modport master (
    input  rx,
    input  uart_cr,
    output po_data,
    output po_flag,
    output parity_err,
    output frame_err,
    output rx_busy
  );

  modport slave (
    output rx,
    output uart_cr,
    input  po_data,
    input  po_flag,
    input  parity_err,
    input  frame_err,
    input  rx_busy
  );
endinterface

// File: rtl/uart_rx_sync2.sv
// Generic two-flop synchroniser for asynchronous inputs; resets to all ones
// so an idle-high line does not produce a spurious edge after reset.
module uart_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back capture stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver on the 125 MHz domain: synchronises rx, frames start, eight
// data bits (LSB first), optional parity and one or two stop bits, and hands
// each byte to the register layer with a one-cycle po_flag and error flags.
module uart_rx
  import uart_pkg::*;
(
  input  logic     clock_125,
  input  logic     rst_n_125,
  uart_rx_if.master bus
);

  logic        rx_s;
  logic        rx_d_q,         rx_d_d;
  uart_state_e state_q,        state_d;
  logic [31:0] cnt_baud_q,     cnt_baud_d;
  logic [31:0] baud_cnt_max_q, baud_cnt_max_d;
  logic        pen_q,          pen_d;
  logic        psel_q,         psel_d;
  logic        stop2_q,        stop2_d;
  logic [2:0]  bit_cnt_q,      bit_cnt_d;
  logic [7:0]  shift_q,        shift_d;
  logic        par_bit_q,      par_bit_d;
  logic        ferr_acc_q,     ferr_acc_d;
  logic [7:0]  po_data_q,      po_data_d;
  logic        po_flag_q,      po_flag_d;
  logic        parity_err_q,   parity_err_d;
  logic        frame_err_q,    frame_err_d;
  logic        rx_busy_q,      rx_busy_d;

  logic        fall;
  logic        sample_pt;
  logic        bit_end;
  logic        unused_cr;

  uart_sync2 #(.WIDTH(1)) u_sync (
    .clk   (clock_125),
    .rst_n (rst_n_125),
    .d     (bus.rx),
    .q     (rx_s)
  );

  // Transmit-enable and reserved control bits belong to uart_tx.
  assign unused_cr = ^{bus.uart_cr[CR_TE], bus.uart_cr[4], bus.uart_cr[7:6]};

  // Next-state, baud timing, sampling and output registration.
  always_comb begin
    fall      = rx_d_q & ~rx_s;
    sample_pt = (cnt_baud_q == (baud_cnt_max_q >> 1));
    bit_end   = (cnt_baud_q == (baud_cnt_max_q - 32'd1));

    rx_d_d         = rx_s;
    state_d        = state_q;
    baud_cnt_max_d = baud_cnt_max_q;
    pen_d          = pen_q;
    psel_d         = psel_q;
    stop2_d        = stop2_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    par_bit_d      = par_bit_q;
    ferr_acc_d     = ferr_acc_q;
    po_data_d      = po_data_q;
    po_flag_d      = 1'b0;
    parity_err_d   = parity_err_q;
    frame_err_d    = frame_err_q;

    if (state_q == IDLE) begin
      cnt_baud_d = '0;
    end else if (bit_end) begin
      cnt_baud_d = '0;
    end else begin
      cnt_baud_d = cnt_baud_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        // Frame configuration tracks uart_cr only while idle.
        baud_cnt_max_d = baud_max(bus.uart_cr[CR_BAUD_HI:CR_BAUD_LO], baud_cnt_max_q);
        pen_d          = bus.uart_cr[CR_PEN];
        psel_d         = bus.uart_cr[CR_PSEL];
        stop2_d        = bus.uart_cr[CR_STOP2];
        bit_cnt_d      = '0;
        ferr_acc_d     = 1'b0;
        if (fall && bus.uart_cr[CR_RE]) begin
          state_d = START_BIT;
        end
      end
      START_BIT: begin
        if (sample_pt && rx_s) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = RECV;
        end
      end
      RECV: begin
        if (sample_pt) begin
          shift_d[bit_cnt_q] = rx_s;
        end
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = pen_q ? PARITY : STOP_BIT1;
          end
        end
      end
      PARITY: begin
        if (sample_pt) begin
          par_bit_d = rx_s;
        end
        if (bit_end) begin
          state_d = STOP_BIT1;
        end
      end
      STOP_BIT1: begin
        // Single-stop frames leave at mid-bit so a start edge right after
        // the stop bit is still caught in IDLE.
        if (sample_pt) begin
          if (!rx_s) begin
            ferr_acc_d = 1'b1;
          end
          if (!stop2_q) begin
            state_d = FINISH;
          end
        end else if (bit_end && stop2_q) begin
          state_d = STOP_BIT2;
        end
      end
      STOP_BIT2: begin
        if (sample_pt) begin
          if (!rx_s) begin
            ferr_acc_d = 1'b1;
          end
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d      = IDLE;
        po_flag_d    = 1'b1;
        po_data_d    = shift_q;
        // Expected parity bit is XOR of the data, inverted for odd parity.
        parity_err_d = pen_q & (par_bit_q != (^shift_q ^ psel_q));
        frame_err_d  = ferr_acc_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rx_busy_d = (state_d != IDLE);
  end

  // All receiver state, asynchronously reset.
  always_ff @(posedge clock_125 or negedge rst_n_125) begin
    if (!rst_n_125) begin
      rx_d_q         <= 1'b1;
      state_q        <= IDLE;
      cnt_baud_q     <= '0;
      baud_cnt_max_q <= BAUD_RESET;
      pen_q          <= 1'b0;
      psel_q         <= 1'b0;
      stop2_q        <= 1'b0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      par_bit_q      <= 1'b0;
      ferr_acc_q     <= 1'b0;
      po_data_q      <= '0;
      po_flag_q      <= 1'b0;
      parity_err_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      rx_busy_q      <= 1'b0;
    end else begin
      rx_d_q         <= rx_d_d;
      state_q        <= state_d;
      cnt_baud_q     <= cnt_baud_d;
      baud_cnt_max_q <= baud_cnt_max_d;
      pen_q          <= pen_d;
      psel_q         <= psel_d;
      stop2_q        <= stop2_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      par_bit_q      <= par_bit_d;
      ferr_acc_q     <= ferr_acc_d;
      po_data_q      <= po_data_d;
      po_flag_q      <= po_flag_d;
      parity_err_q   <= parity_err_d;
      frame_err_q    <= frame_err_d;
      rx_busy_q      <= rx_busy_d;
    end
  end

  assign bus.po_data    = po_data_q;
  assign bus.po_flag    = po_flag_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives serial frames bit by bit and compares every
// delivered byte against a frame-level reference model.
module tb_uart_rx;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rec_t;

  logic clock_125 = 1'b0;
  logic rst_n_125 = 1'b0;

  uart_rx_if u_if ();

  uart_rx dut (
    .clock_125 (clock_125),
    .rst_n_125 (rst_n_125),
    .bus       (u_if)
  );

  always #4 clock_125 = ~clock_125;

  int n_cmp = 0;
  int n_err = 0;

  // Every cycle with po_flag high is logged, so a stretched pulse shows up
  // as an extra record.
  rec_t obs [0:255];
  int   obs_n       = 0;
  int   busy_cycles = 0;

  always @(negedge clock_125) begin
    if (u_if.po_flag === 1'b1) begin
      if (obs_n < 256) obs[obs_n] <= '{u_if.po_data, u_if.parity_err, u_if.frame_err};
      obs_n <= obs_n + 1;
    end
    if (u_if.rx_busy === 1'b1) busy_cycles <= busy_cycles + 1;
  end

  function automatic int clk_per_bit(input int code);
    case (code)
      5:       return 125;
      6:       return 62;
      7:       return 41;
      8:       return 31;
      default: return 25;
    endcase
  endfunction

  function automatic logic [11:0] mk_cr(input bit re, input bit psel, input bit pen,
                                        input bit stop2, input logic [3:0] code);
    return {code, 2'b00, stop2, 1'b0, pen, psel, 1'b0, re};
  endfunction

  // Reference: count ones; parity is wrong if data+parity ones don't give
  // the requested (even/odd) total. Any low stop bit is a framing error.
  function automatic rec_t model(input logic [7:0] b, input bit pen, input bit podd,
                                 input bit pbit, input int nstop, input bit s1, input bit s2);
    rec_t r;
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    r.data = b;
    r.perr = pen && (((ones + int'(pbit)) % 2) != (podd ? 1 : 0));
    r.ferr = !s1 || (nstop == 2 && !s2);
    return r;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clock_125);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit use_par, input bit pbit,
                            input int nstop, input bit s1, input bit s2, input int bc);
    u_if.rx = 1'b0; wait_clks(bc);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = b[i]; wait_clks(bc);
    end
    if (use_par) begin
      u_if.rx = pbit; wait_clks(bc);
    end
    u_if.rx = s1; wait_clks(bc);
    if (nstop == 2) begin
      u_if.rx = s2; wait_clks(bc);
    end
    u_if.rx = 1'b1;
  endtask

  task automatic test_reset();
    wait_clks(3);
    n_cmp++;
    if ({u_if.po_data, u_if.po_flag, u_if.parity_err, u_if.frame_err, u_if.rx_busy} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs: got data=%h flag=%b perr=%b ferr=%b busy=%b, expected all 0",
               u_if.po_data, u_if.po_flag, u_if.parity_err, u_if.frame_err, u_if.rx_busy);
    end
    rst_n_125 = 1'b1;
    wait_clks(5);
    n_cmp++;
    if (u_if.rx_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b expected 0", u_if.rx_busy);
    end
  endtask

  task automatic test_8n1();
    int   start;
    rec_t exp;
    u_if.uart_cr = mk_cr(1, 0, 0, 0, 4'd9);
    wait_clks(4);
    start = obs_n;
    send_frame(8'hA5, 0, 0, 1, 1, 1, 25);
    exp = model(8'hA5, 0, 0, 0, 1, 1, 1);
    wait_clks(50);
    n_cmp++;
    if (obs_n - start !== 1) begin
      n_err++;
      $display("FAIL 8n1_count: got %0d flags, expected 1", obs_n - start);
    end else begin
      n_cmp++;
      if (obs[start] !== exp) begin
        n_err++;
        $display("FAIL 8n1_data: got %h/%b/%b expected %h/%b/%b",
                 obs[start].data, obs[start].perr, obs[start].ferr, exp.data, exp.perr, exp.ferr);
      end
    end
    n_cmp++;
    if ({u_if.po_data, u_if.po_flag} !== {8'hA5, 1'b0}) begin
      n_err++;
      $display("FAIL 8n1_hold: got data=%h flag=%b expected a5/0", u_if.po_data, u_if.po_flag);
    end
  endtask

  task automatic test_parity();
    int   start;
    rec_t exp [4];
    bit   odd  [4] = '{0, 0, 1, 1};
    bit   pb   [4] = '{1, 0, 1, 0};
    start = obs_n;
    for (int k = 0; k < 4; k++) begin
      u_if.uart_cr = mk_cr(1, odd[k], 1, 0, 4'd9);
      wait_clks(4);
      send_frame(8'h03, 1, pb[k], 1, 1, 1, 25);
      exp[k] = model(8'h03, 1, odd[k], pb[k], 1, 1, 1);
      wait_clks(50);
    end
    n_cmp++;
    if (obs_n - start !== 4) begin
      n_err++;
      $display("FAIL parity_count: got %0d flags, expected 4", obs_n - start);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (obs[start+k] !== exp[k]) begin
          n_err++;
          $display("FAIL parity_frame%0d: got %h/%b/%b expected %h/%b/%b", k,
                   obs[start+k].data, obs[start+k].perr, obs[start+k].ferr,
                   exp[k].data, exp[k].perr, exp[k].ferr);
        end
      end
    end
  endtask

  task automatic test_stop2();
    int   start;
    rec_t exp [2];
    bit   s2  [2] = '{0, 1};
    u_if.uart_cr = mk_cr(1, 0, 0, 1, 4'd5);
    wait_clks(4);
    start = obs_n;
    for (int k = 0; k < 2; k++) begin
      send_frame(8'h5A, 0, 0, 2, 1, s2[k], 125);
      exp[k] = model(8'h5A, 0, 0, 0, 2, 1, s2[k]);
      wait_clks(250);
    end
    n_cmp++;
    if (obs_n - start !== 2) begin
      n_err++;
      $display("FAIL stop2_count: got %0d flags, expected 2", obs_n - start);
    end else begin
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs[start+k] !== exp[k]) begin
          n_err++;
          $display("FAIL stop2_frame%0d: got %h/%b/%b expected %h/%b/%b", k,
                   obs[start+k].data, obs[start+k].perr, obs[start+k].ferr,
                   exp[k].data, exp[k].perr, exp[k].ferr);
        end
      end
    end
  endtask

  task automatic test_glitch_and_disable();
    int start;
    int b0;
    u_if.uart_cr = mk_cr(1, 0, 0, 0, 4'd9);
    wait_clks(4);
    start = obs_n;
    u_if.rx = 1'b0;
    wait_clks(2);
    n_cmp++;
    if (u_if.rx_busy !== 1'b0) begin
      n_err++;
      $display("FAIL edge_latency_early: busy=%b expected 0", u_if.rx_busy);
    end
    wait_clks(1);
    n_cmp++;
    if (u_if.rx_busy !== 1'b1) begin
      n_err++;
      $display("FAIL edge_latency: busy=%b expected 1", u_if.rx_busy);
    end
    wait_clks(2);
    u_if.rx = 1'b1;
    for (int i = 0; i < 60 && u_if.rx_busy !== 1'b0; i++) wait_clks(1);
    n_cmp++;
    if (u_if.rx_busy !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_idle: busy=%b expected 0 within 60 clocks", u_if.rx_busy);
    end
    wait_clks(50);
    n_cmp++;
    if (obs_n - start !== 0) begin
      n_err++;
      $display("FAIL glitch_flag: got %0d flags, expected 0", obs_n - start);
    end
    u_if.uart_cr = mk_cr(0, 0, 0, 0, 4'd9);
    wait_clks(4);
    start = obs_n;
    b0    = busy_cycles;
    send_frame(8'hC3, 0, 0, 1, 1, 1, 25);
    wait_clks(50);
    n_cmp++;
    if ((obs_n - start) !== 0 || (busy_cycles - b0) !== 0) begin
      n_err++;
      $display("FAIL re_off: got %0d flags / %0d busy cycles, expected 0/0",
               obs_n - start, busy_cycles - b0);
    end
  endtask

  task automatic test_back_to_back();
    int         start;
    logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h55};
    rec_t       exp;
    u_if.uart_cr = mk_cr(1, 0, 0, 0, 4'd6);
    wait_clks(4);
    start = obs_n;
    for (int k = 0; k < 3; k++) send_frame(bytes[k], 0, 0, 1, 1, 1, 62);
    wait_clks(124);
    n_cmp++;
    if (obs_n - start !== 3) begin
      n_err++;
      $display("FAIL b2b_count: got %0d flags, expected 3", obs_n - start);
    end else begin
      for (int k = 0; k < 3; k++) begin
        exp = model(bytes[k], 0, 0, 0, 1, 1, 1);
        n_cmp++;
        if (obs[start+k] !== exp) begin
          n_err++;
          $display("FAIL b2b_frame%0d: got %h/%b/%b expected %h/%b/%b", k,
                   obs[start+k].data, obs[start+k].perr, obs[start+k].ferr,
                   exp.data, exp.perr, exp.ferr);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int   start;
    rec_t exp;
    u_if.uart_cr = mk_cr(1, 0, 0, 0, 4'd9);
    wait_clks(4);
    start = obs_n;
    u_if.rx = 1'b0; wait_clks(25);
    for (int i = 0; i < 5; i++) begin
      u_if.rx = i[0]; wait_clks(25);
    end
    rst_n_125 = 1'b0;
    #1;
    n_cmp++;
    if ({u_if.po_data, u_if.po_flag, u_if.parity_err, u_if.frame_err, u_if.rx_busy} !== 12'h000) begin
      n_err++;
      $display("FAIL midframe_reset: got data=%h flag=%b perr=%b ferr=%b busy=%b, expected all 0",
               u_if.po_data, u_if.po_flag, u_if.parity_err, u_if.frame_err, u_if.rx_busy);
    end
    u_if.rx = 1'b1;
    wait_clks(3);
    rst_n_125 = 1'b1;
    wait_clks(50);
    n_cmp++;
    if ((obs_n - start) !== 0 || u_if.rx_busy !== 1'b0) begin
      n_err++;
      $display("FAIL midframe_partial: got %0d flags busy=%b, expected 0/0", obs_n - start, u_if.rx_busy);
    end
    send_frame(8'h3C, 0, 0, 1, 1, 1, 25);
    exp = model(8'h3C, 0, 0, 0, 1, 1, 1);
    wait_clks(50);
    n_cmp++;
    if (obs_n - start !== 1) begin
      n_err++;
      $display("FAIL after_reset_count: got %0d flags, expected 1", obs_n - start);
    end else begin
      n_cmp++;
      if (obs[start] !== exp) begin
        n_err++;
        $display("FAIL after_reset_data: got %h/%b/%b expected %h/%b/%b",
                 obs[start].data, obs[start].perr, obs[start].ferr, exp.data, exp.perr, exp.ferr);
      end
    end
  endtask

  task automatic test_random();
    int         start, code, bc, nstop;
    bit         pen, podd, pbit, s1, s2;
    logic [7:0] b;
    rec_t       exp;
    for (int k = 0; k < 16; k++) begin
      code  = int'($urandom_range(5, 9));
      bc    = clk_per_bit(code);
      pen   = 1'($urandom_range(0, 1));
      podd  = 1'($urandom_range(0, 1));
      pbit  = 1'($urandom_range(0, 1));
      nstop = int'($urandom_range(1, 2));
      s1    = ($urandom_range(0, 3) != 0);
      s2    = ($urandom_range(0, 3) != 0);
      b     = 8'($urandom);
      u_if.uart_cr = mk_cr(1, podd, pen, (nstop == 2), 4'(code));
      wait_clks(4);
      start = obs_n;
      send_frame(b, pen, pbit, nstop, s1, s2, bc);
      exp = model(b, pen, podd, pbit, nstop, s1, s2);
      wait_clks(2 * bc);
      n_cmp++;
      if (obs_n - start !== 1) begin
        n_err++;
        $display("FAIL rand%0d_count: got %0d flags, expected 1 (code %0d pen %0b stops %0d)",
                 k, obs_n - start, code, pen, nstop);
      end else begin
        n_cmp++;
        if (obs[start] !== exp) begin
          n_err++;
          $display("FAIL rand%0d_data: got %h/%b/%b expected %h/%b/%b", k,
                   obs[start].data, obs[start].perr, obs[start].ferr, exp.data, exp.perr, exp.ferr);
        end
      end
    end
  endtask

  initial begin
    u_if.rx      = 1'b1;
    u_if.uart_cr = '0;
    test_reset();
    test_8n1();
    test_parity();
    test_stop2();
    test_glitch_and_disable();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
